// File: rtl/gpio_pkg.sv
// gpio_pkg: definitions shared by the Wishbone GPIO peripheral.
// Contents:
//   - Register offsets: the word index taken from adr_i[4:2].
//   - sel_mask(): expands a 4-bit Wishbone byte-lane select into a 32-bit bit mask.
package gpio_pkg;

  localparam logic [2:0] GPIO_DATA_IN    = 3'd0;
  localparam logic [2:0] GPIO_DATA_OUT   = 3'd1;
  localparam logic [2:0] GPIO_DIR        = 3'd2;
  localparam logic [2:0] GPIO_OUT_SET    = 3'd3;
  localparam logic [2:0] GPIO_OUT_CLR    = 3'd4;
  localparam logic [2:0] GPIO_RISE_EN    = 3'd5;
  localparam logic [2:0] GPIO_FALL_EN    = 3'd6;
  localparam logic [2:0] GPIO_IRQ_STATUS = 3'd7;

  // Each select bit covers one byte of the 32-bit data bus.
  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: input synchroniser and edge detector for the GPIO pins.
// Ports:
//   clk, rst_n - system clock and asynchronous active-low reset.
//   gpio_i     - asynchronous pin inputs.
//   sync_o     - pins after SYNC_STAGES flops.
//   rise_o     - per-pin 0->1 transition seen between prev and sync.
//   fall_o     - per-pin 1->0 transition seen between prev and sync.
module gpio_sync_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  // Stage 0 samples the raw pins. Later stages only resolve metastability.
  // prev_q holds the previous synchronised sample for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/wb_gpio_irq.sv
// wb_gpio_irq: Wishbone-classic GPIO slave with edge interrupts.
// Ports:
//   clk, rst_n         - system clock and asynchronous active-low reset.
//   adr_i .. ack_o     - Wishbone slave port. Only adr_i[4:2] is decoded.
//   gpio_i             - asynchronous pin inputs.
//   gpio_o             - pin output values (DATA_OUT).
//   gpio_oe            - pin output enables (DIR, 1 = output).
//   irq_o              - level interrupt, the OR of IRQ_STATUS.
module wb_gpio_irq
  import gpio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      adr_i,
  input  logic [31:0]      dat_i,
  output logic [31:0]      dat_o,
  input  logic             we_i,
  input  logic [3:0]       sel_i,
  input  logic             stb_i,
  input  logic             cyc_i,
  output logic             ack_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq_o
);

  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] status_q, status_d;

  logic [WIDTH-1:0] data_in, rise, fall;
  logic             req;
  logic [2:0]       reg_sel;
  logic [31:0]      byte_mask;
  logic [WIDTH-1:0] lane_mask;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] status_clr;
  logic [31:0]      rd_val;
  logic             unused_bits;

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .gpio_i (gpio_i),
    .sync_o (data_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Masking out ack_q makes every access a single ack pulse, even when the
  // master holds cyc/stb through the ack cycle.
  assign req       = cyc_i & stb_i & ~ack_q;
  assign reg_sel   = adr_i[4:2];
  assign byte_mask = sel_mask(sel_i);
  assign lane_mask = byte_mask[WIDTH-1:0];
  assign wr_bits   = dat_i[WIDTH-1:0] & lane_mask;

  // Upper address bits alias. Data bits above WIDTH are dropped.
  assign unused_bits = ^{adr_i[31:5], adr_i[1:0], byte_mask, dat_i};

  // Register writes and read-data capture on the request edge.
  // The status set from edge events is OR-ed in after the W1C clear, so a
  // simultaneous event wins over a clear of the same bit.
  always_comb begin
    ack_d      = req;
    dat_d      = dat_q;
    out_d      = out_q;
    dir_d      = dir_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    status_clr = '0;
    rd_val     = '0;
    if (req) begin
      if (we_i) begin
        case (reg_sel)
          GPIO_DATA_OUT:   out_d      = (out_q & ~lane_mask) | wr_bits;
          GPIO_DIR:        dir_d      = (dir_q & ~lane_mask) | wr_bits;
          GPIO_OUT_SET:    out_d      = out_q | wr_bits;
          GPIO_OUT_CLR:    out_d      = out_q & ~wr_bits;
          GPIO_RISE_EN:    rise_en_d  = (rise_en_q & ~lane_mask) | wr_bits;
          GPIO_FALL_EN:    fall_en_d  = (fall_en_q & ~lane_mask) | wr_bits;
          GPIO_IRQ_STATUS: status_clr = wr_bits;
          default:         ;
        endcase
      end else begin
        case (reg_sel)
          GPIO_DATA_IN:    rd_val[WIDTH-1:0] = data_in;
          GPIO_DATA_OUT:   rd_val[WIDTH-1:0] = out_q;
          GPIO_DIR:        rd_val[WIDTH-1:0] = dir_q;
          GPIO_RISE_EN:    rd_val[WIDTH-1:0] = rise_en_q;
          GPIO_FALL_EN:    rd_val[WIDTH-1:0] = fall_en_q;
          GPIO_IRQ_STATUS: rd_val[WIDTH-1:0] = status_q;
          default:         rd_val = '0;
        endcase
        dat_d = rd_val;
      end
    end
    status_d = (status_q & ~status_clr) | (rise & rise_en_q) | (fall & fall_en_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      out_q     <= RESET_OUT;
      dir_q     <= RESET_DIR;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
    end else begin
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
    end
  end

  assign ack_o   = ack_q;
  assign dat_o   = dat_q;
  assign gpio_o  = out_q;
  assign gpio_oe = dir_q;
  assign irq_o   = |status_q;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// tb_wb_gpio_irq: directed bench for wb_gpio_irq.
// Structure:
//   - A table of register accesses, each with its expected read data and pin outputs.
//   - Hand-written sequences for interrupt timing, set-beats-clear and reset mid-access.
module tb_wb_gpio_irq;

  localparam int         WIDTH       = 8;
  localparam int         SYNC_STAGES = 2;
  localparam logic [7:0] RST_OUT     = 8'hA5;
  localparam logic [7:0] RST_DIR     = 8'h0F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr_i, dat_i, dat_o;
  logic        we_i, stb_i, cyc_i, ack_o, irq_o;
  logic [3:0]  sel_i;
  logic [7:0]  gpio_i, gpio_o, gpio_oe;

  int checks = 0;
  int passes = 0;

  wb_gpio_irq #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_OUT   (RST_OUT),
    .RESET_DIR   (RST_DIR)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .adr_i   (adr_i),
    .dat_i   (dat_i),
    .dat_o   (dat_o),
    .we_i    (we_i),
    .sel_i   (sel_i),
    .stb_i   (stb_i),
    .cyc_i   (cyc_i),
    .ack_o   (ack_o),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe),
    .irq_o   (irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] expRd;
    logic [7:0]  expOut;
    logic [7:0]  expOe;
  } vec_t;

  vec_t vecs [19];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // One Wishbone access: request at the next negedge, wait (bounded) for ack,
  // capture dat_o, drop the strobe and confirm ack was a single pulse.
  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, output logic [31:0] rdata);
    int waitCycles;
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
    waitCycles = 0;
    do begin
      @(posedge clk); #1;
      waitCycles++;
    end while (!ack_o && waitCycles < 8);
    checkOutput("ack_latency", waitCycles, 32'd1);
    rdata = dat_o;
    @(negedge clk);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk); #1;
    checkOutput("ack_single_pulse", {31'b0, ack_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int k;

    //           we    adr     dat            sel      expRd  out    oe
    vecs[0]  = '{1'b0, 32'h04, 32'h0,         4'hF,    32'hA5, 8'hA5, 8'h0F};
    vecs[1]  = '{1'b0, 32'h08, 32'h0,         4'hF,    32'h0F, 8'hA5, 8'h0F};
    vecs[2]  = '{1'b1, 32'h04, 32'h0,         4'hF,    32'h0,  8'h00, 8'h0F};
    vecs[3]  = '{1'b1, 32'h0C, 32'h81,        4'hF,    32'h0,  8'h81, 8'h0F};
    vecs[4]  = '{1'b1, 32'h10, 32'h01,        4'hF,    32'h0,  8'h80, 8'h0F};
    vecs[5]  = '{1'b0, 32'h04, 32'h0,         4'hF,    32'h80, 8'h80, 8'h0F};
    vecs[6]  = '{1'b1, 32'h04, 32'hFFFFFF3C,  4'b0010, 32'h0,  8'h80, 8'h0F};
    vecs[7]  = '{1'b0, 32'h04, 32'h0,         4'hF,    32'h80, 8'h80, 8'h0F};
    vecs[8]  = '{1'b1, 32'h04, 32'hFFFFFF3C,  4'b0001, 32'h0,  8'h3C, 8'h0F};
    vecs[9]  = '{1'b0, 32'h04, 32'h0,         4'hF,    32'h3C, 8'h3C, 8'h0F};
    vecs[10] = '{1'b0, 32'h0C, 32'h0,         4'hF,    32'h0,  8'h3C, 8'h0F};
    vecs[11] = '{1'b0, 32'h10, 32'h0,         4'hF,    32'h0,  8'h3C, 8'h0F};
    vecs[12] = '{1'b1, 32'h08, 32'h1234,      4'hF,    32'h0,  8'h3C, 8'h34};
    vecs[13] = '{1'b0, 32'h08, 32'h0,         4'hF,    32'h34, 8'h3C, 8'h34};
    vecs[14] = '{1'b0, 32'h24, 32'h0,         4'hF,    32'h3C, 8'h3C, 8'h34};
    vecs[15] = '{1'b1, 32'h00, 32'hFF,        4'hF,    32'h0,  8'h3C, 8'h34};
    vecs[16] = '{1'b0, 32'h00, 32'h0,         4'hF,    32'h0,  8'h3C, 8'h34};
    vecs[17] = '{1'b1, 32'h0C, 32'hFF,        4'h0,    32'h0,  8'h3C, 8'h34};
    vecs[18] = '{1'b0, 32'h1C, 32'h0,         4'hF,    32'h0,  8'h3C, 8'h34};

    rst_n = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    adr_i = '0; dat_i = '0; sel_i = '0; gpio_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_gpio_o", {24'b0, gpio_o}, 32'hA5);
    checkOutput("reset_gpio_oe", {24'b0, gpio_oe}, 32'h0F);
    checkOutput("reset_irq", {31'b0, irq_o}, 32'd0);
    checkOutput("reset_ack", {31'b0, ack_o}, 32'd0);
    checkOutput("reset_dat_o", dat_o, 32'd0);

    // Table-driven register accesses.
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd);
      if (!vecs[i].we) checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].expRd);
      checkOutput($sformatf("vec%0d_gpio_o", i), {24'b0, gpio_o}, {24'b0, vecs[i].expOut});
      checkOutput($sformatf("vec%0d_gpio_oe", i), {24'b0, gpio_oe}, {24'b0, vecs[i].expOe});
      checkOutput($sformatf("vec%0d_irq", i), {31'b0, irq_o}, 32'd0);
    end

    // Rising edge on pin 2: irq exactly SYNC_STAGES edges after first sample.
    applyStimulus(1'b1, 32'h14, 32'h04, 4'hF, rd);
    @(negedge clk); gpio_i[2] = 1'b1;
    for (k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (irq_o) break;
    end
    checkOutput("rise_irq_latency", k, SYNC_STAGES);
    applyStimulus(1'b0, 32'h1C, 32'h0, 4'hF, rd);
    checkOutput("rise_status", rd, 32'h04);
    applyStimulus(1'b0, 32'h00, 32'h0, 4'hF, rd);
    checkOutput("rise_data_in", rd, 32'h04);
    @(negedge clk); gpio_i[2] = 1'b0;
    repeat (5) @(posedge clk);
    applyStimulus(1'b0, 32'h1C, 32'h0, 4'hF, rd);
    checkOutput("fall_no_new_status", rd, 32'h04);
    applyStimulus(1'b1, 32'h1C, 32'h04, 4'hF, rd);
    checkOutput("w1c_irq_low", {31'b0, irq_o}, 32'd0);
    applyStimulus(1'b0, 32'h1C, 32'h0, 4'hF, rd);
    checkOutput("w1c_status", rd, 32'h0);

    // Enabling RISE_EN on a pin already steady high must not raise status.
    @(negedge clk); gpio_i[3] = 1'b1;
    repeat (5) @(posedge clk);
    applyStimulus(1'b1, 32'h14, 32'h0C, 4'hF, rd);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("steady_high_no_irq", {31'b0, irq_o}, 32'd0);

    // Latch status bit 0 through a rising edge, then switch to falling-edge mode.
    applyStimulus(1'b1, 32'h14, 32'h01, 4'hF, rd);
    @(negedge clk); gpio_i[0] = 1'b1;
    repeat (5) @(posedge clk);
    applyStimulus(1'b0, 32'h1C, 32'h0, 4'hF, rd);
    checkOutput("bit0_latched", rd, 32'h01);
    applyStimulus(1'b1, 32'h14, 32'h00, 4'hF, rd);
    applyStimulus(1'b1, 32'h18, 32'h01, 4'hF, rd);
    applyStimulus(1'b0, 32'h1C, 32'h0, 4'hF, rd);
    checkOutput("disable_keeps_status", rd, 32'h01);

    // Falling edge whose status-set edge coincides with the W1C request edge.
    @(negedge clk); gpio_i[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h1C; dat_i = 32'h01; sel_i = 4'hF;
    @(posedge clk); #1;
    checkOutput("sbc_ack", {31'b0, ack_o}, 32'd1);
    checkOutput("sbc_irq_at_ack", {31'b0, irq_o}, 32'd1);
    @(negedge clk); cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk); #1;
    checkOutput("sbc_irq_after", {31'b0, irq_o}, 32'd1);
    applyStimulus(1'b0, 32'h1C, 32'h0, 4'hF, rd);
    checkOutput("sbc_status", rd, 32'h01);

    // Reset asserted together with a write request: no ack, reset values return.
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h04; dat_i = 32'hFF; sel_i = 4'hF;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_mid_no_ack", {31'b0, ack_o}, 32'd0);
    checkOutput("rst_mid_irq", {31'b0, irq_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_mid_ack_after", {31'b0, ack_o}, 32'd0);
    checkOutput("rst_mid_gpio_o", {24'b0, gpio_o}, 32'hA5);
    checkOutput("rst_mid_gpio_oe", {24'b0, gpio_oe}, 32'h0F);
    applyStimulus(1'b0, 32'h04, 32'h0, 4'hF, rd);
    checkOutput("rst_mid_data_out", rd, 32'hA5);
    checkOutput("rst_mid_irq_final", {31'b0, irq_o}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/wb_gpio_irq.md
Name: wb_gpio_irq

Overview:
- Parametrised Wishbone-classic GPIO peripheral; successor to the fixed 4-pin GPIO block.
- Provides WIDTH pins with per-pin direction, atomic set/clear, input synchronisation, and rising/falling edge interrupts with W1C status.
- Sits on the SoC Wishbone bus as a slave; irq_o feeds the core interrupt controller.

Parameters:
- WIDTH, 8, number of GPIO pins, legal range 1..32.
- SYNC_STAGES, 2, input synchroniser depth, legal range 2..3.
- RESET_OUT, 0, reset value of DATA_OUT (WIDTH bits).
- RESET_DIR, 0, reset value of DIR (WIDTH bits, 1 = output).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- adr_i  in  32  Wishbone address; only adr_i[4:2] is decoded.
- dat_i  in  32  write data.
- dat_o  out  32  read data.
- we_i  in  1  write enable.
- sel_i  in  4  byte-lane select.
- stb_i  in  1  strobe.
- cyc_i  in  1  cycle.
- ack_o  out  1  acknowledge.
- gpio_i  in  WIDTH  asynchronous pin inputs.
- gpio_o  out  WIDTH  pin output values (equals DATA_OUT).
- gpio_oe  out  WIDTH  pin output enables (equals DIR).
- irq_o  out  1  level interrupt, equals OR of IRQ_STATUS.

Behaviour:
- Reset values: ack_o=0, dat_o=0, DATA_OUT=RESET_OUT, DIR=RESET_DIR, RISE_EN=0, FALL_EN=0, IRQ_STATUS=0, synchroniser and previous-sample flops=0, irq_o=0.
- Register map (offset = adr_i[4:2]*4; higher address bits alias):
  - 0x00 DATA_IN: RO; synchronised pins.
  - 0x04 DATA_OUT: RW.
  - 0x08 DIR: RW.
  - 0x0C OUT_SET: WO, write-1-sets DATA_OUT bits; reads 0.
  - 0x10 OUT_CLR: WO, write-1-clears DATA_OUT bits; reads 0.
  - 0x14 RISE_EN: RW.
  - 0x18 FALL_EN: RW.
  - 0x1C IRQ_STATUS: RO plus W1C.
- Bus handshake:
  - A request is cyc_i & stb_i & ~ack_o.
  - On the request edge: ack_o <= 1 and the access is performed. ack_o drops the next cycle, so every access completes with exactly one wait-free ack pulse.
  - Back-to-back accesses therefore ack at most every second cycle.
  - Dropping cyc_i while ack_o=1 has no effect; the access is already committed.
- Writes:
  - Honour sel_i per byte lane; lanes with sel_i=0 are unchanged.
  - Only bits [WIDTH-1:0] are stored; upper bits are ignored.
  - Writes to DATA_IN are ignored but still acked.
  - Byte-masked write-1 values for OUT_SET/OUT_CLR/IRQ_STATUS are dat_i AND the expanded sel_i mask.
- Reads: dat_o is registered on the request edge, zero-extended to 32 bits, and valid while ack_o=1. dat_o holds its value otherwise.
- Synchroniser and edge detect:
  - gpio_i passes through a SYNC_STAGES-deep flop chain (sync).
  - A previous-sample register prev <= sync each cycle.
  - rise = sync & ~prev; fall = ~sync & prev.
- Status set:
  - IRQ_STATUS[i] <= 1 when (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]).
  - Edge detection runs on every pin regardless of DIR, which gives output loopback.
- Latency:
  - A pin change first sampled at edge 0 is visible in DATA_IN after edge SYNC_STAGES-1.
  - The status bit and irq_o go high after edge SYNC_STAGES.
  - irq_o is combinational from the status register.
- Simultaneous events:
  - A status set and a W1C of the same bit in the same cycle leaves the bit set; set wins.
  - Enabling RISE_EN while the pin is steady high causes no event, because only transitions count.
  - Disabling an enable does not clear already-latched status.
- Reset asserted mid-transaction: everything returns to reset values immediately and any pending ack is lost. The master must restart the cycle.

Decomposition:
- Shared package gpio_pkg holds:
  - Register offset localparams: GPIO_DATA_IN, GPIO_DATA_OUT, GPIO_DIR, GPIO_OUT_SET, GPIO_OUT_CLR, GPIO_RISE_EN, GPIO_FALL_EN, GPIO_IRQ_STATUS.
  - A function expanding sel_i into a 32-bit byte mask.
- One sub-module, gpio_sync_edge (params WIDTH, SYNC_STAGES):
  - Contains the synchroniser chain, prev register, and rise/fall outputs.
  - Instantiated once inside wb_gpio_irq.

Test Plan:
- Reset check (WIDTH=8, RESET_OUT=8'hA5, RESET_DIR=8'h0F): deassert rst_n, then read 0x04 and 0x08 -> dat_o=0x000000A5 and 0x0000000F. gpio_o=A5, gpio_oe=0F, irq_o=0, single ack pulse per read.
- Atomic output update: write 0x04=0x00, write 0x0C=0x81, write 0x10=0x01, read 0x04 -> 0x00000080. gpio_o=0x80 after the final write's ack edge.
- Byte lanes: write 0x04=0xFFFFFF3C with sel_i=4'b0010 -> DATA_OUT unchanged. Repeat with sel_i=4'b0001 -> DATA_OUT=0x3C.
- Rising-edge interrupt: RISE_EN=0x04, then raise gpio_i[2] -> irq_o high exactly SYNC_STAGES edges later and IRQ_STATUS reads 0x04. Lowering the pin causes no new status. Writing 0x1C=0x04 -> irq_o low the cycle after the ack edge.
- Set-beats-clear: FALL_EN=0x01 with status bit 0 already set. Time a falling edge on gpio_i[0] so its status-set cycle coincides with a W1C of 0x01 -> IRQ_STATUS[0] remains 1 and irq_o stays high.
- Reset mid-access: assert rst_n low in the same cycle as cyc_i&stb_i write to DATA_OUT=0xFF -> no ack, DATA_OUT=RESET_OUT after release, and irq_o=0.
